// File: rtl/div_pkg.sv
// Shared types and constants for the approximate sequential divider family.
package div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DIV_W_DEF = 8;

   // Step counter only has to reach N-1 <= W-1.
   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/approx_div_seq_if.sv
// Operand/result handshake bundle for approx_div_seq; chk_err exists only with DIV_SELFCHECK_EN.
interface approx_div_seq_if #(parameter int W = 8);
   logic           in_valid;
   logic           in_ready;
   logic [2*W-1:0] dividend;
   logic [W-1:0]   divisor;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   quotient;
   logic [W-1:0]   remainder;
   logic           div_zero;
   logic           ovf;
`ifdef DIV_SELFCHECK_EN
   logic           chk_err;

   modport master (output in_valid, dividend, divisor, out_ready,
                   input  in_ready, out_valid, quotient, remainder, div_zero, ovf, chk_err);
   modport slave  (input  in_valid, dividend, divisor, out_ready,
                   output in_ready, out_valid, quotient, remainder, div_zero, ovf, chk_err);
`else
   modport master (output in_valid, dividend, divisor, out_ready,
                   input  in_ready, out_valid, quotient, remainder, div_zero, ovf);
   modport slave  (input  in_valid, dividend, divisor, out_ready,
                   output in_ready, out_valid, quotient, remainder, div_zero, ovf);
`endif
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, conditionally subtract.
module div_step #(
   parameter int W = 8
) (
   input  logic [W:0]   i_p,
   input  logic         i_bit,
   input  logic [W-1:0] i_divisor,
   output logic [W:0]   o_p,
   output logic         o_qbit
);

   logic [W+1:0] w_t;
   logic [W:0]   w_diff;

   assign w_t    = {i_p, i_bit};
   assign o_qbit = (w_t >= {2'b00, i_divisor});
   // When the subtract is taken the difference is below the divisor, so W+1 bits suffice.
   assign w_diff = w_t[W:0] - {1'b0, i_divisor};
   assign o_p    = o_qbit ? w_diff : w_t[W:0];

endmodule

// File: rtl/approx_div_seq.sv
// Sequential 2W/W restoring divider with optional truncated low quotient bits.
// Define DIV_SELFCHECK_EN to add the registered q*d+r consistency check (chk_err).
module approx_div_seq
   import div_pkg::*;
#(
   parameter int W          = DIV_W_DEF,
   parameter int APPROX_LSB = 0
) (
   input logic             clk,
   input logic             rst,
   approx_div_seq_if.slave bus
);

   localparam int            N    = W - APPROX_LSB;
   localparam int            CW   = cnt_w(W);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_accept;
   logic            w_out_valid;
   logic            w_special;

   logic [W:0]      r_p;
   logic [W-1:0]    r_dvd_lo;
   logic [W-1:0]    r_divisor;
   logic [W-1:0]    r_q;
   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    r_quot;
   logic [W-1:0]    r_rem;
   logic            r_div_zero;
   logic            r_ovf;

   logic [W:0]      w_step_p;
   logic            w_qbit;
   logic [W-1:0]    w_q_nxt;

   div_step #(.W(W)) u_step (
      .i_p       (r_p),
      .i_bit     (r_dvd_lo[W-1]),
      .i_divisor (r_divisor),
      .o_p       (w_step_p),
      .o_qbit    (w_qbit)
   );

   assign w_q_nxt   = (r_q << 1) | {{(W-1){1'b0}}, w_qbit};
   assign w_special = (bus.divisor == '0) || (bus.dividend[2*W-1:W] >= bus.divisor);

`ifdef DIV_SELFCHECK_EN
   logic [2*W-1:0] r_dividend;
   logic           r_chk_pend;
   logic           r_chk_err;
   logic [2*W:0]   w_chk_sum;
   logic [2*W:0]   w_chk_ref;

   // The remainder is in units of 2^APPROX_LSB, so it is rescaled before the sum.
   assign w_chk_sum   = ((2*W+1)'(r_quot) * (2*W+1)'(r_divisor))
                        + ((2*W+1)'(r_rem) << APPROX_LSB);
   assign w_chk_ref   = {1'b0, r_dividend} & ~(((2*W+1)'(1) << APPROX_LSB) - (2*W+1)'(1));
   assign w_out_valid = (r_state == ST_DONE) && !r_chk_pend;
   assign bus.chk_err = r_chk_err;
`else
   assign w_out_valid = (r_state == ST_DONE);
`endif

   assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
   assign bus.out_valid = w_out_valid;
   assign bus.quotient  = r_quot;
   assign bus.remainder = r_rem;
   assign bus.div_zero  = r_div_zero;
   assign bus.ovf       = r_ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = w_special ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            if (r_cnt == LAST) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (w_out_valid && bus.out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p        <= '0;
         r_dvd_lo   <= '0;
         r_divisor  <= '0;
         r_q        <= '0;
         r_cnt      <= '0;
         r_quot     <= '0;
         r_rem      <= '0;
         r_div_zero <= 1'b0;
         r_ovf      <= 1'b0;
`ifdef DIV_SELFCHECK_EN
         r_dividend <= '0;
         r_chk_pend <= 1'b0;
         r_chk_err  <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_p       <= {1'b0, bus.dividend[2*W-1:W]};
                  r_dvd_lo  <= bus.dividend[W-1:0];
                  r_divisor <= bus.divisor;
                  r_q       <= '0;
                  r_cnt     <= '0;
`ifdef DIV_SELFCHECK_EN
                  r_dividend <= bus.dividend;
                  r_chk_err  <= 1'b0;
`endif
                  if (bus.divisor == '0) begin
                     r_div_zero <= 1'b1;
                     r_quot     <= '1;
                     r_rem      <= bus.dividend[W-1:0];
                  end else if (bus.dividend[2*W-1:W] >= bus.divisor) begin
                     r_ovf  <= 1'b1;
                     r_quot <= '1;
                     r_rem  <= '0;
                  end
               end
            end
            ST_CALC: begin
               r_p      <= w_step_p;
               r_q      <= w_q_nxt;
               r_dvd_lo <= r_dvd_lo << 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_quot <= w_q_nxt << APPROX_LSB;
                  r_rem  <= w_step_p[W-1:0];
`ifdef DIV_SELFCHECK_EN
                  r_chk_pend <= 1'b1;
`endif
               end
            end
            ST_DONE: begin
`ifdef DIV_SELFCHECK_EN
               if (r_chk_pend) begin
                  r_chk_err  <= (w_chk_sum != w_chk_ref);
                  r_chk_pend <= 1'b0;
               end
`endif
               if (w_out_valid && bus.out_ready) begin
                  r_div_zero <= 1'b0;
                  r_ovf      <= 1'b0;
`ifdef DIV_SELFCHECK_EN
                  r_chk_err  <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_approx_div_seq.sv
// Directed + random bench for approx_div_seq, running exact (APPROX_LSB=0) and truncated (APPROX_LSB=2) instances side by side.
module tb_approx_div_seq;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   approx_div_seq_if #(.W(8)) ifc0 ();
   approx_div_seq_if #(.W(8)) ifc2 ();

   approx_div_seq #(.W(8), .APPROX_LSB(0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
   approx_div_seq #(.W(8), .APPROX_LSB(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division on the dividend shifted right by the truncation amount.
   function automatic void model(input logic [15:0] a, input logic [7:0] b, input int k,
                                 output logic [7:0] q, output logic [7:0] r,
                                 output logic dz, output logic ov, output int lat);
      int s;
      dz = 1'b0;
      ov = 1'b0;
      if (b == 8'd0) begin
         dz = 1'b1; q = 8'hFF; r = a[7:0]; lat = 1;
      end else if (int'(a) / 256 >= int'(b)) begin
         ov = 1'b1; q = 8'hFF; r = 8'd0; lat = 1;
      end else begin
         s   = int'(a) >> k;
         q   = 8'((s / int'(b)) << k);
         r   = 8'(s % int'(b));
         lat = 8 - k + 1;
      end
   endfunction

   task automatic set_in(input logic v, input logic [15:0] a, input logic [7:0] b);
      ifc0.in_valid = v; ifc0.dividend = a; ifc0.divisor = b;
      ifc2.in_valid = v; ifc2.dividend = a; ifc2.divisor = b;
   endtask

   // Issue one division to both instances, measure latency, optionally hold backpressure, then drain.
   task automatic run(input string nm, input logic [15:0] a, input logic [7:0] b, input int hold);
      logic [7:0] q0, r0, q2, r2;
      logic       dz0, ov0, dz2, ov2;
      int         lt0, lt2, l0, l2, n;
      model(a, b, 0, q0, r0, dz0, ov0, lt0);
      model(a, b, 2, q2, r2, dz2, ov2, lt2);
      ifc0.out_ready = 1'b0;
      ifc2.out_ready = 1'b0;
      set_in(1'b1, a, b);
      n = 0; l0 = 0; l2 = 0;
      while ((l0 == 0 || l2 == 0) && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == 1) set_in(1'b0, 16'hDEAD, 8'h5A);
         if (l0 == 0 && ifc0.out_valid) l0 = n;
         if (l2 == 0 && ifc2.out_valid) l2 = n;
      end
      chk({nm, ".lat0"}, l0, lt0);
      chk({nm, ".lat2"}, l2, lt2);
      chk({nm, ".q0"},   ifc0.quotient,  q0);
      chk({nm, ".r0"},   ifc0.remainder, r0);
      chk({nm, ".dz0"},  ifc0.div_zero,  dz0);
      chk({nm, ".ov0"},  ifc0.ovf,       ov0);
      chk({nm, ".q2"},   ifc2.quotient,  q2);
      chk({nm, ".r2"},   ifc2.remainder, r2);
      chk({nm, ".dz2"},  ifc2.div_zero,  dz2);
      chk({nm, ".ov2"},  ifc2.ovf,       ov2);
      for (int i = 0; i < hold; i++) begin
         set_in(1'b1, 16'h0102, 8'h03);
         @(negedge clk);
         chk({nm, ".hold.vld"}, ifc0.out_valid, 1'b1);
         chk({nm, ".hold.rdy"}, ifc0.in_ready,  1'b0);
         chk({nm, ".hold.q"},   ifc0.quotient,  q0);
         chk({nm, ".hold.r"},   ifc0.remainder, r0);
      end
      set_in(1'b0, 16'h0, 8'h0);
      ifc0.out_ready = 1'b1;
      ifc2.out_ready = 1'b1;
      @(negedge clk);
      ifc0.out_ready = 1'b0;
      ifc2.out_ready = 1'b0;
      chk({nm, ".drain.vld0"}, ifc0.out_valid, 1'b0);
      chk({nm, ".drain.rdy0"}, ifc0.in_ready,  1'b1);
      chk({nm, ".drain.dz0"},  ifc0.div_zero,  1'b0);
      chk({nm, ".drain.ov0"},  ifc0.ovf,       1'b0);
      chk({nm, ".drain.vld2"}, ifc2.out_valid, 1'b0);
      chk({nm, ".drain.rdy2"}, ifc2.in_ready,  1'b1);
   endtask

   initial begin
      logic [15:0] a;
      logic [7:0]  b;
      int          seen;
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      set_in(1'b0, 16'h0, 8'h0);
      ifc0.out_ready = 1'b0;
      ifc2.out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst.rdy",  ifc0.in_ready,  1'b0);
      chk("rst.vld",  ifc0.out_valid, 1'b0);
      chk("rst.q",    ifc0.quotient,  8'h00);
      chk("rst.r",    ifc0.remainder, 8'h00);
      chk("rst.dz",   ifc0.div_zero,  1'b0);
      chk("rst.ov",   ifc0.ovf,       1'b0);
      rst = 1'b0;
      #1;
      chk("rel.rdy0", ifc0.in_ready, 1'b1);
      chk("rel.rdy2", ifc2.in_ready, 1'b1);
      @(negedge clk);

      run("t1000_37", 16'd1000, 8'd37, 0);
      run("tmax",     16'hFEFF, 8'hFF, 0);
      run("tovf",     16'h2000, 8'h10, 0);
      run("tdz",      16'h1234, 8'h00, 0);
      run("tbp",      16'd1000, 8'd37, 5);

      // Reset in the middle of CALC: the division is abandoned silently.
      set_in(1'b1, 16'd1000, 8'd37);
      @(posedge clk);
      @(negedge clk);
      set_in(1'b0, 16'h0, 8'h0);
      chk("mid.busy", ifc0.in_ready, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid.vld0", ifc0.out_valid, 1'b0);
      chk("mid.rdy0", ifc0.in_ready,  1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid.rdy",  ifc0.in_ready, 1'b1);
      chk("mid.q",    ifc0.quotient, 8'h00);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ifc0.out_valid || ifc2.out_valid) seen++;
      end
      chk("mid.noout", seen, 0);
      run("tafter", 16'd1000, 8'd37, 0);

      for (int i = 0; i < 25; i++) begin
         b = 8'($urandom_range(1, 255));
         case ($urandom_range(0, 9))
            0:       begin b = 8'd0; a = 16'($urandom); end
            1:       a = 16'($urandom);
            default: a = 16'($urandom_range(0, int'(b) * 256 - 1));
         endcase
         run($sformatf("rnd%0d", i), a, b, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/approx_div_seq.md
Name: approx_div_seq

Overview:
- Sequential 2W/W restoring divider; the inverse operation to the team's 8x8 approximate multiplier.
- Recovers an operand from a 16-bit product: quotient = product / known operand.
- Optional truncation of the final quotient bits trades accuracy for latency, matching the inexact-arithmetic flavour of the multiplier family.
- Sits between a multiplier result stream and downstream consumers, with valid/ready handshakes on both sides.

Parameters:
- W, 8, divisor/quotient/remainder width; dividend is 2W.
- APPROX_LSB, 0, number of low quotient bits not computed (0..W-1); they are forced to 0.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept; high only in IDLE.
- dividend  input  2W  numerator (e.g. multiplier product).
- divisor  input  W  denominator.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- quotient  output  W  result quotient.
- remainder  output  W  result remainder.
- div_zero  output  1  divisor was 0.
- ovf  output  1  quotient does not fit in W bits.
- chk_err  output  1  present only with DIV_SELFCHECK_EN.

Behaviour:
- Reset: async assert forces state IDLE; quotient, remainder, out_valid, div_zero, ovf and chk_err go to 0, and all internal registers clear. in_ready is 0 while rst is high and 1 in IDLE after release. Reset mid-operation aborts the division with no output.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Accept on in_valid & in_ready; latch the operands.
  - If divisor==0: next state DONE, div_zero=1, quotient=all ones, remainder=dividend[W-1:0].
  - Else if dividend[2W-1:W] >= divisor: next state DONE, ovf=1, quotient=all ones, remainder=0.
  - Else: next state CALC. Partial remainder P (W+1 bits) = dividend[2W-1:W], step counter = 0.
- CALC: one quotient bit per cycle, N = W-APPROX_LSB iterations, MSB first.
  - T = {P[W-1:0], next dividend bit}.
  - If T >= divisor: P = T-divisor, qbit=1. Else P = T, qbit=0.
  - After the N-th iteration go to DONE.
  - quotient = {N computed bits, APPROX_LSB zeros}.
  - remainder = P[W-1:0], i.e. the exact remainder of (dividend >> APPROX_LSB) / divisor.
- Latency:
  - Normal case: out_valid rises N+1 edges after the accepting edge.
  - div_zero/ovf case: out_valid rises 1 edge after the accepting edge.
- DONE:
  - out_valid=1; quotient, remainder and flags are stable.
  - On out_ready: next state IDLE, out_valid=0, flags cleared.
  - out_valid & out_ready and a new in_valid in the same cycle: the new input is not accepted (in_ready=0 in DONE). Acceptance happens in the next cycle at the earliest; no bubble-free back-to-back.
- Inputs are ignored outside IDLE. Operand changes while busy have no effect.
- Unsigned arithmetic throughout. All W-bit results are truncated with no saturation except the defined all-ones quotient.

Optional Feature:
- Macro: DIV_SELFCHECK_EN.
- Defined:
  - Port chk_err exists.
  - On entering DONE (normal path only), the block computes quotient*divisor + remainder with an exact multiply. It compares against the dividend with its low APPROX_LSB bits masked.
  - chk_err=1 on mismatch and is valid with out_valid.
  - chk_err=0 on the div_zero/ovf paths.
  - The extra multiply is one pipeline register, so normal-path latency becomes N+2.
- Undefined: no chk_err port, no multiply logic, latency N+1.

Decomposition:
- Shared package div_pkg holds:
  - state enum (IDLE, CALC, DONE);
  - default width constant 8;
  - localparam helper for the counter width, clog2(W).
- One natural sub-module: div_step, a combinational single-iteration shift/compare/subtract returning next P and qbit. It is reusable for an unrolled variant later.

Test Plan:
- W=8, APPROX_LSB=0: dividend=1000, divisor=37 -> quotient=27, remainder=1, flags 0, out_valid 9 edges after accept.
- dividend=0xFEFF, divisor=0xFF -> quotient=255, remainder=254, ovf=0 (max legal case).
- Overflow: dividend=0x2000, divisor=0x10 -> ovf=1, quotient=0xFF, remainder=0, out_valid 1 edge after accept.
- div_zero: dividend=0x1234, divisor=0 -> div_zero=1, quotient=0xFF, remainder=0x34.
- APPROX_LSB=2: dividend=1000, divisor=37 -> quotient=24, remainder=28, out_valid 7 edges after accept.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout.
  - Assert rst at CALC step 3 -> immediate IDLE, out_valid=0, no result.
  - Next transaction 1000/37 is correct.
